// File: rtl/memoria_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : memoria_pkg
//  Description : Shared widths, FSM state encodings and requester ids for the
//                16x4 asynchronous memory arbiter/sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package memoria_pkg;

    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 4;

    // Wait counter width; comfortably covers any sensible RD_WAIT/WR_WAIT/TURN.
    localparam int c_CNT_W = 8;

    typedef logic [2:0] state_t;

    localparam state_t c_IDLE    = 3'd0;
    localparam state_t c_RD      = 3'd1;
    localparam state_t c_W_TURN  = 3'd2;
    localparam state_t c_W_DRIVE = 3'd3;
    localparam state_t c_W_REL   = 3'd4;

    localparam logic c_REQ_A = 1'b0;
    localparam logic c_REQ_B = 1'b1;

endpackage
`default_nettype wire

// File: rtl/memoria_arbiter_ctrl_rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-input round-robin arbiter. The grant is combinational;
//                the last-granted requester is remembered so that, with both
//                requests pending, the other requester wins next time.
//  Ports       : clk, rst       clock / async active-high reset
//                i_en           arbitration enable (controller idle)
//                i_req_a/b      requests
//                o_gnt_valid    a grant is being issued this cycle
//                o_gnt_id       granted requester (c_REQ_A / c_REQ_B)
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter2
    import memoria_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_req_a,
    input  logic i_req_b,
    output logic o_gnt_valid,
    output logic o_gnt_id
);

    logic r_last;

    always_comb begin
        o_gnt_valid = i_en & (i_req_a | i_req_b);
        if (i_req_a && i_req_b) begin
            o_gnt_id = ~r_last;
        end else if (i_req_a) begin
            o_gnt_id = c_REQ_A;
        end else begin
            o_gnt_id = c_REQ_B;
        end
    end

    // Reset to B so that A wins the very first contended grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= c_REQ_B;
        end else if (o_gnt_valid) begin
            r_last <= o_gnt_id;
        end
    end

endmodule
`default_nettype wire

// File: rtl/memoria_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : memoria_arbiter_ctrl
//  Description : Two-requester arbiter and timing sequencer for a shared 16x4
//                asynchronous memory (WR=1 read, WR=0 write, shared 4-bit
//                bidirectional data bus).
//  Ports       : clk, reset              clock / async active-high reset
//                req_x, we_x, addr_x,    requester A/B handshake inputs
//                wdata_x
//                ack_a, ack_b            one-cycle completion pulses
//                rdata                   last read data (valid in read ack)
//                busy                    controller not idle
//                mem_wr, mem_addr,       memory interface; mem_data driven
//                mem_data                only while the write driver is on
//  Revision    : 1.0  initial release
// ============================================================================
module memoria_arbiter_ctrl
    import memoria_pkg::*;
#(
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2,
    parameter int TURN    = 1
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              ack_a,
    output logic              ack_b,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    inout  wire  [DATA_W-1:0] mem_data
);

    // A counter loaded with N keeps its state for N+1 cycles.
    localparam logic [c_CNT_W-1:0] c_RD_LOAD   = c_CNT_W'(RD_WAIT);
    localparam logic [c_CNT_W-1:0] c_WR_LOAD   = c_CNT_W'(WR_WAIT);
    localparam logic [c_CNT_W-1:0] c_TURN_LOAD = c_CNT_W'(TURN);
    localparam logic [c_CNT_W-1:0] c_ONE       = c_CNT_W'(1);

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_owner;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_drive_en;

    logic                w_gnt_valid;
    logic                w_gnt_id;
    logic                w_we;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;

    rr_arbiter2 u_arb (
        .clk         (clk),
        .rst         (reset),
        .i_en        (r_state == c_IDLE),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_id    (w_gnt_id)
    );

    // Winner's transaction fields.
    always_comb begin
        w_we    = we_b;
        w_addr  = addr_b;
        w_wdata = wdata_b;
        if (w_gnt_id == c_REQ_A) begin
            w_we    = we_a;
            w_addr  = addr_a;
            w_wdata = wdata_a;
        end
    end

    assign mem_data = r_drive_en ? r_wdata : {DATA_W{1'bz}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_owner    <= c_REQ_A;
            r_wdata    <= '0;
            r_drive_en <= 1'b0;
            mem_wr     <= 1'b1;
            mem_addr   <= '0;
            ack_a      <= 1'b0;
            ack_b      <= 1'b0;
            rdata      <= '0;
            busy       <= 1'b0;
        end else begin
            ack_a <= 1'b0;
            ack_b <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_gnt_valid) begin
                        r_owner  <= w_gnt_id;
                        r_wdata  <= w_wdata;
                        mem_addr <= w_addr;
                        busy     <= 1'b1;
                        if (w_we) begin
                            r_state <= c_W_TURN;
                            r_cnt   <= c_TURN_LOAD;
                            mem_wr  <= 1'b0;
                        end else begin
                            r_state <= c_RD;
                            r_cnt   <= c_RD_LOAD;
                        end
                    end
                end
                c_RD: begin
                    if (r_cnt == '0) begin
                        rdata   <= mem_data;
                        ack_a   <= (r_owner == c_REQ_A);
                        ack_b   <= (r_owner == c_REQ_B);
                        r_state <= c_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - c_ONE;
                    end
                end
                c_W_TURN: begin
                    // WR is already low with the bus floating; the memory
                    // may latch a junk word here, overwritten in W_DRIVE.
                    if (r_cnt == '0) begin
                        r_state    <= c_W_DRIVE;
                        r_cnt      <= c_WR_LOAD;
                        r_drive_en <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - c_ONE;
                    end
                end
                c_W_DRIVE: begin
                    if (r_cnt == '0) begin
                        // Raise WR while still driving so data is stable at
                        // the rising edge of WR.
                        r_state <= c_W_REL;
                        mem_wr  <= 1'b1;
                        ack_a   <= (r_owner == c_REQ_A);
                        ack_b   <= (r_owner == c_REQ_B);
                    end else begin
                        r_cnt <= r_cnt - c_ONE;
                    end
                end
                c_W_REL: begin
                    r_drive_en <= 1'b0;
                    r_state    <= c_IDLE;
                    busy       <= 1'b0;
                end
                default: begin
                    r_state    <= c_IDLE;
                    r_drive_en <= 1'b0;
                    mem_wr     <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memoria_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memoria_arbiter_ctrl
//  Description : Self-checking bench for memoria_arbiter_ctrl. Two DUTs
//                (default timing and RD_WAIT=3/WR_WAIT=1/TURN=2), each with a
//                behavioural 16x4 asynchronous memory on its data bus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_memoria_arbiter_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_a [2], req_b [2], we_a [2], we_b [2];
    logic [3:0] addr_a [2], addr_b [2], wdata_a [2], wdata_b [2];
    logic       ack_a_v [2], ack_b_v [2], busy_v [2], mwr [2];
    logic [3:0] rdata_v [2], maddr [2];
    wire  [3:0] md0, md1;

    logic       mem_oe [2];
    logic [3:0] mem_q [2];
    logic [3:0] mem [2][16];
    time        t_rise [2], t_addr [2];
    logic       prev_wr [2];
    logic [3:0] prev_addr [2];

    logic [3:0] ref_mem [2][16];
    logic [3:0] last_rd [2];
    int         lat_rd [2] = '{3, 4};
    int         lat_wr [2] = '{5, 5};

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic       port;
        logic       we;
        logic [3:0] addr;
        logic [3:0] wdata;
        int         lat;
        logic [3:0] rd;
    } vec_t;
    vec_t tbl [12];

    always #30 clk = ~clk;

    assign md0 = mem_oe[0] ? mem_q[0] : 4'bzzzz;
    assign md1 = mem_oe[1] ? mem_q[1] : 4'bzzzz;

    memoria_arbiter_ctrl #(.RD_WAIT(2), .WR_WAIT(2), .TURN(1)) dut0 (
        .clk(clk), .reset(reset),
        .req_a(req_a[0]), .req_b(req_b[0]), .we_a(we_a[0]), .we_b(we_b[0]),
        .addr_a(addr_a[0]), .addr_b(addr_b[0]),
        .wdata_a(wdata_a[0]), .wdata_b(wdata_b[0]),
        .ack_a(ack_a_v[0]), .ack_b(ack_b_v[0]), .rdata(rdata_v[0]),
        .busy(busy_v[0]), .mem_wr(mwr[0]), .mem_addr(maddr[0]), .mem_data(md0)
    );

    memoria_arbiter_ctrl #(.RD_WAIT(3), .WR_WAIT(1), .TURN(2)) dut1 (
        .clk(clk), .reset(reset),
        .req_a(req_a[1]), .req_b(req_b[1]), .we_a(we_a[1]), .we_b(we_b[1]),
        .addr_a(addr_a[1]), .addr_b(addr_b[1]),
        .wdata_a(wdata_a[1]), .wdata_b(wdata_b[1]),
        .ack_a(ack_a_v[1]), .ack_b(ack_b_v[1]), .rdata(rdata_v[1]),
        .busy(busy_v[1]), .mem_wr(mwr[1]), .mem_addr(maddr[1]), .mem_data(md1)
    );

    // Behavioural asynchronous memory: writes while WR is low, drives the bus
    // only once WR has been high for 150 time units.
    initial begin
        for (int u = 0; u < 2; u++) begin
            for (int a = 0; a < 16; a++) mem[u][a] = 4'h0;
            t_rise[u] = 0; t_addr[u] = 0; prev_wr[u] = 1'b1;
            prev_addr[u] = 4'h0; mem_oe[u] = 1'b0; mem_q[u] = 4'h0;
        end
        forever begin
            #1;
            for (int u = 0; u < 2; u++) begin
                if (mwr[u] && !prev_wr[u]) t_rise[u] = $time;
                if (maddr[u] != prev_addr[u]) t_addr[u] = $time;
                prev_wr[u]   = mwr[u];
                prev_addr[u] = maddr[u];
                if (!mwr[u]) mem[u][maddr[u]] = (u == 0) ? md0 : md1;
                mem_oe[u] = mwr[u] && (($time - t_rise[u]) >= 150);
                mem_q[u]  = mem[u][maddr[u]];
            end
        end
    end

    // The write driver may overlap WR=1 only in W_REL, which is the write ack cycle.
    always @(negedge clk) begin
        if (!reset) begin
            n_vec++;
            if (dut0.r_drive_en && mwr[0] && !(ack_a_v[0] || ack_b_v[0])) begin
                n_fail++;
                $display("FAIL bus_safety u0 at %0t: drive_en=1 mem_wr=1 without ack, required drive_en=0", $time);
            end
            if (dut1.r_drive_en && mwr[1] && !(ack_a_v[1] || ack_b_v[1])) begin
                n_fail++;
                $display("FAIL bus_safety u1 at %0t: drive_en=1 mem_wr=1 without ack, required drive_en=0", $time);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    // One transaction from idle: checks latency, access timing, rdata, ack width.
    task automatic xact(input int u, input logic port, input logic we, input logic [3:0] addr,
                        input logic [3:0] wd, input int exp_lat, input logic [3:0] exp_rd,
                        input string nm);
        int  n;
        logic got;
        time tcap;
        n = 0;
        while (busy_v[u] && n < 20) begin @(posedge clk); #1; n++; end
        if (port) begin
            we_b[u] = we; addr_b[u] = addr; wdata_b[u] = wd; req_b[u] = 1'b1;
        end else begin
            we_a[u] = we; addr_a[u] = addr; wdata_a[u] = wd; req_a[u] = 1'b1;
        end
        n = 0; got = 1'b0;
        while (!got && n < 30) begin
            @(posedge clk); #1; n++;
            got = port ? ack_b_v[u] : ack_a_v[u];
        end
        tcap = $time - 1;
        if (port) req_b[u] = 1'b0; else req_a[u] = 1'b0;
        chk({nm, "_lat"}, n - 1, exp_lat);
        if (!we)
            chk({nm, "_access"}, 32'(((tcap - t_addr[u]) >= 150) && ((tcap - t_rise[u]) >= 150)), 1);
        chk({nm, "_rdata"}, rdata_v[u], exp_rd);
        @(posedge clk); #1;
        chk({nm, "_ackpulse"}, 32'({ack_a_v[u], ack_b_v[u]}), 0);
    endtask

    task automatic run_rand(input int u, input int cnt);
        logic       p, w;
        logic [3:0] a, d, e;
        for (int i = 0; i < cnt; i++) begin
            p = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            a = 4'($urandom_range(0, 15));
            d = 4'($urandom_range(0, 15));
            if (w) begin
                e = last_rd[u];
                ref_mem[u][a] = d;
            end else begin
                e = ref_mem[u][a];
                last_rd[u] = e;
            end
            xact(u, p, w, a, d, w ? lat_wr[u] : lat_rd[u], e, $sformatf("rand_u%0d_%0d", u, i));
        end
    endtask

    initial begin
        int   n, na, nb, k, acks;
        int   first;
        int   ord [4];
        logic [3:0] rds [4];
        logic [3:0] rd_b;

        for (int u = 0; u < 2; u++) begin
            req_a[u] = 0; req_b[u] = 0; we_a[u] = 0; we_b[u] = 0;
            addr_a[u] = 0; addr_b[u] = 0; wdata_a[u] = 0; wdata_b[u] = 0;
            last_rd[u] = 4'h0;
            for (int a = 0; a < 16; a++) ref_mem[u][a] = 4'h0;
        end
        reset = 1'b1;
        // Contention set up before reset release: A writes 1<=5, B reads 1.
        we_a[0] = 1; addr_a[0] = 4'h1; wdata_a[0] = 4'h5; req_a[0] = 1;
        we_b[0] = 0; addr_b[0] = 4'h1; req_b[0] = 1;

        #50;
        chk("rst_mem_wr", mwr[0], 1);
        chk("rst_mem_addr", maddr[0], 0);
        chk("rst_drive_en", dut0.r_drive_en, 0);
        chk("rst_acks", {ack_a_v[0], ack_b_v[0]}, 0);
        chk("rst_rdata", rdata_v[0], 0);
        chk("rst_busy", busy_v[0], 0);
        #50 reset = 1'b0;

        // Contention at reset release: A (write) first, then B reads 4'h5.
        n = 0; na = -1; nb = -1; first = -1; rd_b = 4'h0;
        while (nb < 0 && n < 40) begin
            @(posedge clk); #1; n++;
            if (ack_a_v[0] && na < 0) begin
                na = n; req_a[0] = 0;
                if (first < 0) first = 0;
            end
            if (ack_b_v[0] && nb < 0) begin
                nb = n; req_b[0] = 0; rd_b = rdata_v[0];
                if (first < 0) first = 1;
            end
        end
        chk("cont_first", first, 0);
        chk("cont_a_lat", na - 1, 5);
        chk("cont_b_lat", nb - 1, 10);
        chk("cont_b_rdata", rd_b, 4'h5);
        ref_mem[0][1] = 4'h5; last_rd[0] = 4'h5;

        // Both holding read requests: grants alternate A,B,A,B.
        we_a[0] = 0; addr_a[0] = 4'h1; req_a[0] = 1;
        we_b[0] = 0; addr_b[0] = 4'h1; req_b[0] = 1;
        for (int i = 0; i < 4; i++) begin ord[i] = 9; rds[i] = 4'h0; end
        k = 0; n = 0;
        while (k < 4 && n < 60) begin
            @(posedge clk); #1; n++;
            if (ack_a_v[0]) begin ord[k] = 0; rds[k] = rdata_v[0]; k++; end
            else if (ack_b_v[0]) begin ord[k] = 1; rds[k] = rdata_v[0]; k++; end
        end
        req_a[0] = 0; req_b[0] = 0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("alt_order%0d", i), ord[i], i % 2);
            chk($sformatf("alt_rdata%0d", i), rds[i], 4'h5);
        end

        // Directed table on the default-timing instance.
        tbl[0]  = '{1'b0, 1'b1, 4'h3, 4'hA, 5, 4'h5};
        tbl[1]  = '{1'b0, 1'b0, 4'h3, 4'h0, 3, 4'hA};
        tbl[2]  = '{1'b1, 1'b1, 4'h7, 4'hC, 5, 4'hA};
        tbl[3]  = '{1'b1, 1'b0, 4'h7, 4'h0, 3, 4'hC};
        tbl[4]  = '{1'b0, 1'b1, 4'h0, 4'hF, 5, 4'hC};
        tbl[5]  = '{1'b1, 1'b1, 4'hF, 4'h1, 5, 4'hC};
        tbl[6]  = '{1'b0, 1'b0, 4'hF, 4'h0, 3, 4'h1};
        tbl[7]  = '{1'b1, 1'b0, 4'h0, 4'h0, 3, 4'hF};
        tbl[8]  = '{1'b0, 1'b0, 4'h3, 4'h0, 3, 4'hA};
        tbl[9]  = '{1'b1, 1'b1, 4'h3, 4'h6, 5, 4'hA};
        tbl[10] = '{1'b0, 1'b0, 4'h3, 4'h0, 3, 4'h6};
        tbl[11] = '{1'b1, 1'b0, 4'h7, 4'h0, 3, 4'hC};
        for (int i = 0; i < 12; i++) begin
            xact(0, tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata,
                 tbl[i].lat, tbl[i].rd, $sformatf("vec%0d", i));
            if (tbl[i].we) ref_mem[0][tbl[i].addr] = tbl[i].wdata;
            last_rd[0] = tbl[i].rd;
        end

        run_rand(0, 500);

        // Alternate timing instance: read latency 4, write latency 5.
        xact(1, 1'b0, 1'b1, 4'h2, 4'hD, 5, 4'h0, "sweep_wr0");
        xact(1, 1'b0, 1'b0, 4'h2, 4'h0, 4, 4'hD, "sweep_rd0");
        xact(1, 1'b1, 1'b1, 4'h2, 4'h1, 5, 4'hD, "sweep_wr1");
        xact(1, 1'b0, 1'b0, 4'h2, 4'h0, 4, 4'h1, "sweep_rd1");
        ref_mem[1][2] = 4'h1; last_rd[1] = 4'h1;
        run_rand(1, 60);

        // Reset in the middle of a write's drive phase.
        xact(0, 1'b0, 1'b1, 4'h4, 4'h9, 5, last_rd[0], "pre_rst_wr");
        we_a[0] = 1; addr_a[0] = 4'h9; wdata_a[0] = 4'h3; req_a[0] = 1;
        repeat (3) begin @(posedge clk); #1; end
        chk("rst_mid_wr_low", mwr[0], 0);
        #10 reset = 1'b1;
        #1;
        chk("rst_mid_mem_wr", mwr[0], 1);
        chk("rst_mid_drive_en", dut0.r_drive_en, 0);
        chk("rst_mid_acks", {ack_a_v[0], ack_b_v[0]}, 0);
        chk("rst_mid_rdata", rdata_v[0], 0);
        chk("rst_mid_busy", busy_v[0], 0);
        req_a[0] = 0;
        #20 reset = 1'b0;
        acks = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ack_a_v[0] || ack_b_v[0]) acks++;
        end
        chk("rst_mid_no_ack", acks, 0);
        last_rd[0] = 4'h0;
        xact(0, 1'b1, 1'b0, 4'h4, 4'h0, 3, 4'h9, "post_rst_rd");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
